tr_rst_seq: RTL

//  Parametrised multi-lane transceiver reset sequencer; replaces the vendor reset IP beside the PMA/fPLL wrappers.
//  One shared TX PLL and LANES PMA lanes. One TX FSM drives PLL powerdown and TX resets; one RX FSM per lane.

---
 rtl/tr_rst_seq.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/tr_rst_seq.sv
// tr_rst_seq: multi-lane transceiver reset sequencer.
// One shared TX FSM (PLL powerdown + TX resets) and one RX FSM per lane with
// CDR-lock debounce, CDR timeout re-reset, lock-loss recovery and soft reset.
// Optional feature macro: TR_RST_SEQ_STAT_EN adds rx_relock_cnt, a per-lane
// 8-bit saturating count of RX_RDY exits (cleared only by rst_glbl_n).
module tr_rst_seq #(
  parameter int LANES    = 1,
  parameter int T_PLL_PD = 1000,
  parameter int T_TX_DIG = 200,
  parameter int T_RX_ANA = 1000,
  parameter int T_LTD    = 5000,
  parameter int T_CDR_TO = 65535
) (
  input  logic             clk_glbl,
  input  logic             rst_glbl_n,
  input  logic             pll_locked,
  input  logic             pll_cal_busy,
  output logic             pll_powerdown,
  input  logic [LANES-1:0] tx_cal_busy,
  input  logic [LANES-1:0] rx_cal_busy,
  input  logic [LANES-1:0] rx_is_lockedtodata,
  input  logic [LANES-1:0] rx_soft_rst,
  output logic [LANES-1:0] tx_analogreset,
  output logic [LANES-1:0] tx_digitalreset,
  output logic [LANES-1:0] tx_ready,
  output logic [LANES-1:0] rx_analogreset,
  output logic [LANES-1:0] rx_digitalreset,
  output logic [LANES-1:0] rx_ready
`ifdef TR_RST_SEQ_STAT_EN
  ,
  output logic [8*LANES-1:0] rx_relock_cnt
`endif
);

  // Counter widths sized to the largest terminal value each counter reaches.
  localparam int TX_MAX = (T_PLL_PD > T_TX_DIG) ? T_PLL_PD : T_TX_DIG;
  localparam int TX_W   = $clog2(TX_MAX + 1);
  localparam int RA_W   = $clog2(T_RX_ANA + 1);
  localparam int LTD_W  = $clog2(T_LTD + 1);
  localparam int TO_W   = $clog2(T_CDR_TO + 1);

  localparam logic [TX_W-1:0]  PD_LAST  = TX_W'(T_PLL_PD - 1);
  localparam logic [TX_W-1:0]  DIG_LAST = TX_W'(T_TX_DIG - 1);
  localparam logic [RA_W-1:0]  ANA_LAST = RA_W'(T_RX_ANA - 1);
  localparam logic [LTD_W-1:0] LTD_LAST = LTD_W'(T_LTD - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(T_CDR_TO - 1);

  localparam int SYNC_W = 2 + 3 * LANES;

  typedef enum logic [1:0] {TX_PD, TX_LOCK, TX_ANA, TX_RDY} tx_state_t;
  typedef enum logic [1:0] {RX_ANA, RX_CDR, RX_RDY} rx_state_t;

  logic [1:0]        rst_sync_r;
  logic              run_s;
  logic [SYNC_W-1:0] raw_s;
  logic [SYNC_W-1:0] sync1_r;
  logic [SYNC_W-1:0] sync2_r;

  logic              pll_locked_s;
  logic              pll_cal_busy_s;
  logic              tx_busy_s;
  logic [LANES-1:0]  rx_cal_busy_s;
  logic [LANES-1:0]  ltd_s;

  // Reset asserts immediately; the FSM run enable is released through two flops.
  always_ff @(posedge clk_glbl or negedge rst_glbl_n) begin
    if (!rst_glbl_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign run_s = rst_sync_r[1];

  assign raw_s = {rx_is_lockedtodata, rx_cal_busy, tx_cal_busy, pll_cal_busy, pll_locked};

  // Two-flop synchronisers for every asynchronous status input.
  always_ff @(posedge clk_glbl or negedge rst_glbl_n) begin
    if (!rst_glbl_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  assign pll_locked_s   = sync2_r[0];
  assign pll_cal_busy_s = sync2_r[1];
  assign tx_busy_s      = |sync2_r[2 +: LANES];
  assign rx_cal_busy_s  = sync2_r[2 + LANES +: LANES];
  assign ltd_s          = sync2_r[2 + 2 * LANES +: LANES];

  tx_state_t         tx_state_r;
  logic [TX_W-1:0]   tx_cnt_r;
  logic              pll_pd_r;
  logic              tx_ana_r;
  logic              tx_dig_r;
  logic              tx_rdy_r;

  // Shared TX sequence: PLL powerdown, lock wait, analog then digital release.
  always_ff @(posedge clk_glbl or negedge rst_glbl_n) begin
    if (!rst_glbl_n) begin
      tx_state_r <= TX_PD;
      tx_cnt_r   <= '0;
      pll_pd_r   <= 1'b1;
      tx_ana_r   <= 1'b1;
      tx_dig_r   <= 1'b1;
      tx_rdy_r   <= 1'b0;
    end else if (!run_s) begin
      tx_state_r <= TX_PD;
      tx_cnt_r   <= '0;
      pll_pd_r   <= 1'b1;
      tx_ana_r   <= 1'b1;
      tx_dig_r   <= 1'b1;
      tx_rdy_r   <= 1'b0;
    end else begin
      case (tx_state_r)
        TX_PD: begin
          if (tx_cnt_r == PD_LAST) begin
            tx_state_r <= TX_LOCK;
            tx_cnt_r   <= '0;
            pll_pd_r   <= 1'b0;
          end else begin
            tx_cnt_r <= tx_cnt_r + TX_W'(1);
          end
        end
        TX_LOCK: begin
          if (pll_locked_s && !pll_cal_busy_s && !tx_busy_s) begin
            tx_state_r <= TX_ANA;
            tx_cnt_r   <= '0;
            tx_ana_r   <= 1'b0;
          end
        end
        TX_ANA: begin
          if (tx_cnt_r == DIG_LAST) begin
            tx_state_r <= TX_RDY;
            tx_cnt_r   <= '0;
            tx_dig_r   <= 1'b0;
            tx_rdy_r   <= 1'b1;
          end else begin
            tx_cnt_r <= tx_cnt_r + TX_W'(1);
          end
        end
        TX_RDY: begin
          if (!pll_locked_s) begin
            tx_state_r <= TX_PD;
            tx_cnt_r   <= '0;
            pll_pd_r   <= 1'b1;
            tx_ana_r   <= 1'b1;
            tx_dig_r   <= 1'b1;
            tx_rdy_r   <= 1'b0;
          end
        end
        default: begin
          tx_state_r <= TX_PD;
          tx_cnt_r   <= '0;
          pll_pd_r   <= 1'b1;
          tx_ana_r   <= 1'b1;
          tx_dig_r   <= 1'b1;
          tx_rdy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign pll_powerdown   = pll_pd_r;
  assign tx_analogreset  = {LANES{tx_ana_r}};
  assign tx_digitalreset = {LANES{tx_dig_r}};
  assign tx_ready        = {LANES{tx_rdy_r}};

  for (genvar i = 0; i < LANES; i++) begin : g_rx
    rx_state_t         state_r;
    logic [RA_W-1:0]   ana_cnt_r;
    logic [LTD_W-1:0]  ltd_cnt_r;
    logic [TO_W-1:0]   to_cnt_r;
    logic              ana_r;
    logic              dig_r;
    logic              rdy_r;

    // Per-lane RX sequence; soft reset outranks lock loss and CDR timeout.
    always_ff @(posedge clk_glbl or negedge rst_glbl_n) begin
      if (!rst_glbl_n) begin
        state_r   <= RX_ANA;
        ana_cnt_r <= '0;
        ltd_cnt_r <= '0;
        to_cnt_r  <= '0;
        ana_r     <= 1'b1;
        dig_r     <= 1'b1;
        rdy_r     <= 1'b0;
      end else if (!run_s || rx_soft_rst[i]) begin
        state_r   <= RX_ANA;
        ana_cnt_r <= '0;
        ltd_cnt_r <= '0;
        to_cnt_r  <= '0;
        ana_r     <= 1'b1;
        dig_r     <= 1'b1;
        rdy_r     <= 1'b0;
      end else begin
        case (state_r)
          RX_ANA: begin
            if (ana_cnt_r == ANA_LAST) begin
              if (!rx_cal_busy_s[i]) begin
                state_r   <= RX_CDR;
                ana_cnt_r <= '0;
                ana_r     <= 1'b0;
              end
            end else begin
              ana_cnt_r <= ana_cnt_r + RA_W'(1);
            end
          end
          RX_CDR: begin
            if (ltd_s[i] && (ltd_cnt_r == LTD_LAST)) begin
              state_r   <= RX_RDY;
              ltd_cnt_r <= '0;
              to_cnt_r  <= '0;
              dig_r     <= 1'b0;
              rdy_r     <= 1'b1;
            end else if (to_cnt_r == TO_LAST) begin
              state_r   <= RX_ANA;
              ltd_cnt_r <= '0;
              to_cnt_r  <= '0;
              ana_r     <= 1'b1;
            end else begin
              to_cnt_r  <= to_cnt_r + TO_W'(1);
              ltd_cnt_r <= ltd_s[i] ? (ltd_cnt_r + LTD_W'(1)) : '0;
            end
          end
          RX_RDY: begin
            if (!ltd_s[i]) begin
              state_r   <= RX_CDR;
              ltd_cnt_r <= '0;
              to_cnt_r  <= '0;
              dig_r     <= 1'b1;
              rdy_r     <= 1'b0;
            end
          end
          default: begin
            state_r   <= RX_ANA;
            ana_cnt_r <= '0;
            ltd_cnt_r <= '0;
            to_cnt_r  <= '0;
            ana_r     <= 1'b1;
            dig_r     <= 1'b1;
            rdy_r     <= 1'b0;
          end
        endcase
      end
    end

    assign rx_analogreset[i]  = ana_r;
    assign rx_digitalreset[i] = dig_r;
    assign rx_ready[i]        = rdy_r;

`ifdef TR_RST_SEQ_STAT_EN
    logic [7:0] relock_r;
    logic       rdy_exit_s;

    // Any departure from RX_RDY (lock loss or soft reset) is one relock event.
    assign rdy_exit_s = run_s && (state_r == RX_RDY) && (rx_soft_rst[i] || !ltd_s[i]);

    // Saturating relock statistic; survives soft reset, cleared by global reset.
    always_ff @(posedge clk_glbl or negedge rst_glbl_n) begin
      if (!rst_glbl_n) begin
        relock_r <= 8'd0;
      end else if (rdy_exit_s && (relock_r != 8'hFF)) begin
        relock_r <= relock_r + 8'd1;
      end else begin
        relock_r <= relock_r;
      end
    end

    assign rx_relock_cnt[8*i +: 8] = relock_r;
`endif
  end

endmodule
